instr_decode: RTL and testbench

//  Decode stage of the single-cycle RV32I core; consumes the 32-bit Instruction_code from the fetch stage.

---
 rtl/instr_decode.sv | 259 +++++++++++++++++++++++++
 tb/tb_instr_decode.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// RV32I decode stage: 32x32 register file with write-through bypass, immediate
// generation, main control decode and a retired-instruction counter.
module instr_decode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_code,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;

  assign opcode   = Instruction_code[6:0];
  assign rd_addr  = Instruction_code[11:7];
  assign funct3   = Instruction_code[14:12];
  assign rs1_addr = Instruction_code[19:15];
  assign rs2_addr = Instruction_code[24:20];
  assign funct7   = Instruction_code[31:25];

  // Immediate formats, all sign-extended from bit 31.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{(XLEN-12){Instruction_code[31]}}, Instruction_code[31:20]};
  assign imm_s = {{(XLEN-12){Instruction_code[31]}}, Instruction_code[31:25],
                  Instruction_code[11:7]};
  assign imm_b = {{(XLEN-13){Instruction_code[31]}}, Instruction_code[31], Instruction_code[7],
                  Instruction_code[30:25], Instruction_code[11:8], 1'b0};
  assign imm_u = XLEN'($signed({Instruction_code[31:12], 12'b0}));
  assign imm_j = {{(XLEN-21){Instruction_code[31]}}, Instruction_code[31], Instruction_code[19:12],
                  Instruction_code[20], Instruction_code[30:21], 1'b0};

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  alu_op_e         alu_op;
  logic [XLEN-1:0] imm_sel;
  logic            src_imm;
  logic            wr_rd;
  logic            ld;
  logic            st;
  logic            br;
  logic            jmp;
  logic            bad;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = '0;
    src_imm = 1'b0;
    wr_rd   = 1'b0;
    ld      = 1'b0;
    st      = 1'b0;
    br      = 1'b0;
    jmp     = 1'b0;
    bad     = 1'b0;
    case (opcode)
      OP_R: begin
        wr_rd = 1'b1;
        if (funct7 == F7_BASE) begin
          alu_op = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_op = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        wr_rd   = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_i;
        alu_op  = base_op(funct3);
        // Shift-immediates reuse imm[11:5] as funct7.
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            bad = 1'b1;
          end
        end
      end
      OP_LOAD: begin
        wr_rd   = 1'b1;
        ld      = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_i;
        bad     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        st      = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_s;
        bad     = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        br      = 1'b1;
        imm_sel = imm_b;
        alu_op  = ALU_SUB;
        bad     = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI: begin
        wr_rd   = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_u;
        alu_op  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        wr_rd   = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_u;
      end
      OP_JAL: begin
        wr_rd   = 1'b1;
        jmp     = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_j;
      end
      OP_JALR: begin
        wr_rd   = 1'b1;
        jmp     = 1'b1;
        src_imm = 1'b1;
        imm_sel = imm_i;
        bad     = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
  end

  // An illegal encoding must never change architectural state.
  assign imm       = imm_sel;
  assign alu_ctrl  = alu_op;
  assign alu_src   = src_imm;
  assign illegal   = bad;
  assign reg_write = wr_rd & ~bad;
  assign mem_read  = ld & ~bad;
  assign mem_write = st & ~bad;
  assign branch    = br & ~bad;
  assign jump      = jmp & ~bad;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != 5'd0) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  assign instret_d = bad ? instret_q : instret_q + CNT_W'(1);

  // NOTE: the register file is built from flops and cleared by reset, so it cannot map onto a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
      instret_q <= '0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  // Write-through bypass lets a consumer see the value being written this cycle.
  always_comb begin
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wb_en && wb_addr == rs1_addr) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wb_en && wb_addr == rs2_addr) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them; a CNT_W=4 copy exercises counter wrap.
module tb_instr_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_ctrl;
  logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [63:0] instret;

  logic [31:0] d4_rs1_data, d4_rs2_data, d4_imm;
  logic [4:0]  d4_rd_addr;
  logic [3:0]  d4_alu_ctrl;
  logic        d4_alu_src, d4_reg_write, d4_mem_read, d4_mem_write, d4_branch, d4_jump, d4_illegal;
  logic [3:0]  d4_instret;

  instr_decode dut (
    .clk(clk), .reset(reset), .Instruction_code(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .imm(imm),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal), .instret(instret)
  );

  instr_decode #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Instruction_code(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data(d4_rs1_data), .rs2_data(d4_rs2_data), .rd_addr(d4_rd_addr), .imm(d4_imm),
    .alu_ctrl(d4_alu_ctrl), .alu_src(d4_alu_src), .reg_write(d4_reg_write),
    .mem_read(d4_mem_read), .mem_write(d4_mem_write), .branch(d4_branch), .jump(d4_jump),
    .illegal(d4_illegal), .instret(d4_instret)
  );

  typedef enum {
    F_RS1, F_RS2, F_RD, F_IMM, F_ALU, F_SRC, F_RW, F_MR, F_MW, F_BR, F_JMP, F_ILL,
    F_INSTRET, F_INSTRET4
  } fld_e;

  typedef struct {
    fld_e        fld;
    logic [63:0] exp;
    string       name;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] cnt;
  bit          cur_legal;

  function automatic logic [63:0] actual(fld_e f);
    case (f)
      F_RS1:      return {32'b0, rs1_data};
      F_RS2:      return {32'b0, rs2_data};
      F_RD:       return {59'b0, rd_addr};
      F_IMM:      return {32'b0, imm};
      F_ALU:      return {60'b0, alu_ctrl};
      F_SRC:      return {63'b0, alu_src};
      F_RW:       return {63'b0, reg_write};
      F_MR:       return {63'b0, mem_read};
      F_MW:       return {63'b0, mem_write};
      F_BR:       return {63'b0, branch};
      F_JMP:      return {63'b0, jump};
      F_ILL:      return {63'b0, illegal};
      F_INSTRET:  return instret;
      default:    return {60'b0, d4_instret};
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [63:0] act;
    act = actual(e.fld);
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so drain the queue at each negedge.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      check(sbq.pop_front());
    end
  end

  task automatic put(input fld_e f, input logic [63:0] v, input string n);
    exp_t e;
    e.fld  = f;
    e.exp  = v;
    e.name = n;
    sbq.push_back(e);
  endtask

  task automatic chk_cnt(input string n);
    put(F_INSTRET, cnt, n);
    put(F_INSTRET4, {60'b0, cnt[3:0]}, {n, "_w4"});
  endtask

  task automatic set_ins(input logic [31:0] v, input bit legal);
    instr     = v;
    cur_legal = legal;
  endtask

  // Advance one clock; the counter model follows the instruction held across the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset && cur_legal) cnt = cnt + 64'd1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = '0; cnt = '0;
    set_ins(NOP, 1'b1);
    tick(); tick();

    // Reset state, reading x5/x6 via add x0,x5,x6
    set_ins(32'h0062_8033, 1'b1);
    put(F_RS1, 64'h0, "rst_rs1"); put(F_RS2, 64'h0, "rst_rs2"); chk_cnt("rst_cnt");
    tick();

    reset = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5_0005;
    put(F_RS1, 64'hA5A5_0005, "bypass_rs1"); put(F_RS2, 64'h0, "bypass_rs2_untouched");
    tick();
    wb_en = 1'b0;
    put(F_RS1, 64'hA5A5_0005, "x5_stored"); chk_cnt("cnt_after_1");
    tick();

    // Asynchronous reset in mid-cycle, with a write pending to x6
    reset = 1'b1; cnt = '0;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0066;
    put(F_RS1, 64'h0, "async_rst_x5"); chk_cnt("async_rst_cnt");
    tick();
    reset = 1'b0; wb_en = 1'b0;
    put(F_RS2, 64'h0, "write_lost_in_reset"); put(F_RS1, 64'h0, "x5_cleared"); chk_cnt("cnt_after_rst");
    tick();

    // x0 writes dropped
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    set_ins(NOP, 1'b1);
    put(F_RS1, 64'h0, "x0_no_bypass");
    tick();
    wb_en = 1'b0;
    put(F_RS1, 64'h0, "x0_read"); chk_cnt("cnt_x0");
    tick();

    // add x1,x7,x7 with same-cycle write of x7
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
    set_ins(32'h0073_80B3, 1'b1);
    put(F_RS1, 64'h1234_5678, "add_rs1_bypass"); put(F_RS2, 64'h1234_5678, "add_rs2_bypass");
    put(F_ALU, 64'd0, "add_alu"); put(F_RW, 64'd1, "add_rw"); put(F_SRC, 64'd0, "add_src");
    put(F_IMM, 64'h0, "add_imm"); put(F_RD, 64'd1, "add_rd"); put(F_ILL, 64'd0, "add_ill");
    tick();

    // sub x3,x7,x6 with rs2-only bypass
    wb_addr = 5'd6; wb_data = 32'h0F0F_0000;
    set_ins(32'h4063_81B3, 1'b1);
    put(F_RS1, 64'h1234_5678, "sub_rs1_stored"); put(F_RS2, 64'h0F0F_0000, "sub_rs2_bypass");
    put(F_ALU, 64'd1, "sub_alu"); put(F_RD, 64'd3, "sub_rd");
    tick();
    wb_en = 1'b0;

    set_ins(32'hFFF0_0093, 1'b1);
    put(F_IMM, 64'hFFFF_FFFF, "addi_imm"); put(F_SRC, 64'd1, "addi_src");
    put(F_ALU, 64'd0, "addi_alu"); put(F_RW, 64'd1, "addi_rw");
    tick();

    set_ins(32'hFE00_0EE3, 1'b1);
    put(F_IMM, 64'hFFFF_FFFC, "beq_imm"); put(F_BR, 64'd1, "beq_branch");
    put(F_ALU, 64'd1, "beq_alu"); put(F_RW, 64'd0, "beq_rw"); put(F_SRC, 64'd0, "beq_src");
    put(F_JMP, 64'd0, "beq_jump");
    tick();

    set_ins(32'h1234_50B7, 1'b1);
    put(F_IMM, 64'h1234_5000, "lui_imm"); put(F_ALU, 64'd10, "lui_alu");
    put(F_SRC, 64'd1, "lui_src"); put(F_RW, 64'd1, "lui_rw"); put(F_RD, 64'd1, "lui_rd");
    tick();

    set_ins(32'hFE20_AC23, 1'b1);
    put(F_IMM, 64'hFFFF_FFF8, "sw_imm"); put(F_MW, 64'd1, "sw_mem_write");
    put(F_MR, 64'd0, "sw_mem_read"); put(F_RW, 64'd0, "sw_rw"); put(F_ALU, 64'd0, "sw_alu");
    tick();

    set_ins(32'h0101_2203, 1'b1);
    put(F_IMM, 64'h10, "lw_imm"); put(F_MR, 64'd1, "lw_mem_read");
    put(F_RW, 64'd1, "lw_rw"); put(F_RD, 64'd4, "lw_rd");
    tick();

    set_ins(32'h0080_00EF, 1'b1);
    put(F_IMM, 64'h8, "jal_imm"); put(F_JMP, 64'd1, "jal_jump");
    put(F_RW, 64'd1, "jal_rw"); put(F_ALU, 64'd0, "jal_alu");
    tick();

    set_ins(32'h4032_D293, 1'b1);
    put(F_ALU, 64'd7, "srai_alu"); put(F_IMM, 64'h403, "srai_imm");
    put(F_ILL, 64'd0, "srai_ill"); put(F_RW, 64'd1, "srai_rw");
    tick();

    // mul is outside RV32I: bad funct7
    set_ins(32'h0220_8033, 1'b0);
    put(F_ILL, 64'd1, "mul_ill"); put(F_RW, 64'd0, "mul_rw"); chk_cnt("cnt_before_mul");
    tick();

    set_ins(32'hFFFF_FFFF, 1'b0);
    put(F_ILL, 64'd1, "ones_ill"); put(F_RW, 64'd0, "ones_rw"); put(F_MW, 64'd0, "ones_mw");
    put(F_MR, 64'd0, "ones_mr"); put(F_BR, 64'd0, "ones_br"); put(F_JMP, 64'd0, "ones_jmp");
    chk_cnt("cnt_after_mul");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt("illegal_hold");
    end

    // Count legal cycles until the 4-bit counter reaches all-ones, then wrap
    set_ins(NOP, 1'b1);
    while (cnt[3:0] != 4'hF) tick();
    put(F_INSTRET4, 64'hF, "pre_wrap_ones"); chk_cnt("pre_wrap");
    tick();
    put(F_INSTRET4, 64'h0, "wrap_to_zero"); chk_cnt("post_wrap");
    tick();
    tick();

    if (sbq.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
      bad = bad + sbq.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
